// File: rtl/sc_reg_countdown_timer.sv
// sc_reg_countdown_timer: prescaled loadable down-counter with IDLE/RUN/PAUSE/DONE control.
// Define SC_REGCOUNTDOWN_AUTORELOAD_EN to restart from the last loaded value on terminal count.
module sc_reg_countdown_timer #(
  parameter int RegCOUNTDOWN_DATAWIDTH      = 4,
  parameter int RegCOUNTDOWN_PRESCALE_MAX   = 49999999,
  parameter int RegCOUNTDOWN_PRESCALE_WIDTH = 26
) (
  input  logic                              SC_RegCOUNTDOWN_CLOCK_50,
  input  logic                              SC_RegCOUNTDOWN_RESET_InHigh,
  input  logic                              SC_RegCOUNTDOWN_clear_InHigh,
  input  logic                              SC_RegCOUNTDOWN_load_InHigh,
  input  logic [RegCOUNTDOWN_DATAWIDTH-1:0] SC_RegCOUNTDOWN_data_InBUS,
  input  logic                              SC_RegCOUNTDOWN_start_InHigh,
  input  logic                              SC_RegCOUNTDOWN_pause_InHigh,
  output logic [RegCOUNTDOWN_DATAWIDTH-1:0] SC_RegCOUNTDOWN_data_OutBUS,
  output logic                              SC_RegCOUNTDOWN_zero_OutHigh,
  output logic                              SC_RegCOUNTDOWN_done_OutHigh,
  output logic                              SC_RegCOUNTDOWN_busy_OutHigh
);
  localparam int DW = RegCOUNTDOWN_DATAWIDTH;
  localparam int PW = RegCOUNTDOWN_PRESCALE_WIDTH;
  localparam logic [PW-1:0] PMAX = PW'(RegCOUNTDOWN_PRESCALE_MAX);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] count_q, count_d;
  logic [PW-1:0] pre_q, pre_d;
  logic done_q, done_d;
  logic active;
`ifdef SC_REGCOUNTDOWN_AUTORELOAD_EN
  logic [DW-1:0] reload_q, reload_d;
`endif
  assign active = (state_q == RUN) || (state_q == PAUSE);
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
`ifdef SC_REGCOUNTDOWN_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (SC_RegCOUNTDOWN_clear_InHigh) begin
      state_d = IDLE;
      count_d = '0;
      pre_d   = '0;
    end else if (SC_RegCOUNTDOWN_load_InHigh) begin
      count_d = SC_RegCOUNTDOWN_data_InBUS;
      pre_d   = '0;
`ifdef SC_REGCOUNTDOWN_AUTORELOAD_EN
      reload_d = SC_RegCOUNTDOWN_data_InBUS;
`endif
      state_d = (active && SC_RegCOUNTDOWN_data_InBUS != '0) ? state_q : IDLE;
    end else if (state_q == IDLE) begin
      if (SC_RegCOUNTDOWN_start_InHigh && count_q != '0) begin
        state_d = RUN;
        pre_d   = '0;
      end
    end else if (active) begin
      // releasing pause counts in the same cycle, so each paused cycle costs exactly one
      if (SC_RegCOUNTDOWN_pause_InHigh) state_d = PAUSE;
      else begin
        state_d = RUN;
        if (pre_q == PMAX) begin
          pre_d = '0;
          if (count_q == DW'(1)) begin
            done_d = 1'b1;
`ifdef SC_REGCOUNTDOWN_AUTORELOAD_EN
            count_d = reload_q;
`else
            count_d = '0;
            state_d = DONE;
`endif
          end else count_d = count_q - DW'(1);
        end else pre_d = pre_q + PW'(1);
      end
    end
  end
  always_ff @(posedge SC_RegCOUNTDOWN_CLOCK_50 or posedge SC_RegCOUNTDOWN_RESET_InHigh) begin
    if (SC_RegCOUNTDOWN_RESET_InHigh) begin
      state_q <= IDLE;
      count_q <= '0;
      pre_q   <= '0;
      done_q  <= 1'b0;
`ifdef SC_REGCOUNTDOWN_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
`ifdef SC_REGCOUNTDOWN_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end
  assign SC_RegCOUNTDOWN_data_OutBUS  = count_q;
  assign SC_RegCOUNTDOWN_zero_OutHigh = (count_q == '0);
  assign SC_RegCOUNTDOWN_done_OutHigh = done_q;
  assign SC_RegCOUNTDOWN_busy_OutHigh = active;
endmodule

// File: doc/sc_reg_countdown_timer.md
Name: sc_reg_countdown_timer

Overview:
Loadable down-counter with a clock prescaler and a run/pause/done control state machine. It is the decrementing counterpart of the team's general up-counting register. It gives the game logic a countdown (race timer, fuel, respawn delay) with a single-cycle terminal-count pulse. It sits between the game-control FSM, which loads, starts, pauses and clears it, and the display/score path, which reads the count.

Parameters:
RegCOUNTDOWN_DATAWIDTH, 4, width of count and load value
RegCOUNTDOWN_PRESCALE_MAX, 49999999, clock cycles per count step minus one (one step per second at 50 MHz)
RegCOUNTDOWN_PRESCALE_WIDTH, 26, prescaler register width; must hold PRESCALE_MAX

Ports:
SC_RegCOUNTDOWN_CLOCK_50  input  1  system clock, rising-edge
SC_RegCOUNTDOWN_RESET_InHigh  input  1  asynchronous reset, active-high
SC_RegCOUNTDOWN_clear_InHigh  input  1  synchronous clear to IDLE, count 0
SC_RegCOUNTDOWN_load_InHigh  input  1  load count from data_InBUS
SC_RegCOUNTDOWN_data_InBUS  input  DATAWIDTH  load value
SC_RegCOUNTDOWN_start_InHigh  input  1  start counting (IDLE only)
SC_RegCOUNTDOWN_pause_InHigh  input  1  level; holds counting while high
SC_RegCOUNTDOWN_data_OutBUS  output  DATAWIDTH  current count
SC_RegCOUNTDOWN_zero_OutHigh  output  1  level; count == 0
SC_RegCOUNTDOWN_done_OutHigh  output  1  one-cycle pulse on terminal count
SC_RegCOUNTDOWN_busy_OutHigh  output  1  state is RUN or PAUSE

Behaviour:
- One clock; reset is asynchronous and active-high. Ports are SC_RegCOUNTDOWN_CLOCK_50 and SC_RegCOUNTDOWN_RESET_InHigh.
- Reset (asynchronous, any time, including mid-run):
  - state IDLE, count 0, prescaler 0, reload register 0.
  - done 0, busy 0, zero 1.
- All outputs are registered or derived from registers only.
  - zero = (count == 0).
  - busy = (state is RUN or PAUSE).
- States: IDLE, RUN, PAUSE, DONE. Control priority per cycle: clear > load > start > pause.
- clear, in any state: next state IDLE, count 0, prescaler 0, no done pulse.
- load:
  - count <= data_InBUS, prescaler <= 0, reload register <= data_InBUS.
  - In IDLE or DONE: next state IDLE.
  - In RUN or PAUSE with nonzero data: state unchanged (the countdown restarts from the new value).
  - In RUN or PAUSE with data 0: next state IDLE, no done pulse.
- start:
  - Honoured only in IDLE with count != 0: next state RUN, prescaler 0.
  - Ignored in all other cases, including count == 0 and starts during RUN, PAUSE or DONE.
- RUN, pause low:
  - prescaler increments each cycle.
  - When prescaler == PRESCALE_MAX: prescaler <= 0 and count <= count-1.
  - If that decrement takes count from 1 to 0: next state DONE, done asserted the following cycle for exactly one cycle.
- RUN, pause high: next state PAUSE. No prescaler increment or decrement in that cycle.
- PAUSE: prescaler and count hold. Pause low returns to RUN, and increments resume on the next cycle.
- DONE: count held at 0, busy 0. Only load or clear leave it.
- Latency: with P = PRESCALE_MAX and start sampled at edge k, the first decrement happens at edge k+P+1. Done is high during the cycle after edge k+N*(P+1) for load value N. Each paused cycle adds one cycle.
- Arithmetic: unsigned, DATAWIDTH bits. Count never decrements below 0 and there is no wrap-around.

Optional Feature:
SC_REGCOUNTDOWN_AUTORELOAD_EN
- Defined: on the 1 -> 0 transition in RUN, count <= reload register instead of 0. done pulses for one cycle and the state stays RUN. DONE is never entered from RUN, and zero is never asserted during the run. The countdown repeats until clear, load 0, or reset.
- Undefined: behaviour as above. The reload register may be optimised away.

Test Plan:
- PRESCALE_MAX=3, load 5, start -> count 5,4,3,2,1,0 stepping every 4 cycles; done high for exactly 1 cycle, 20 cycles after the start edge; zero=1; busy=0; state DONE.
- Load 5, start, pause high for 10 cycles after the 2nd decrement -> count holds at 3, busy=1; done arrives 30 cycles after start.
- Load 9, start, after 3 decrements load 7 -> count=7, prescaler restarts, done 28 cycles after the reload; load 0 during RUN -> IDLE, no done.
- Clear and load 6 asserted in the same cycle during RUN -> count=0, state IDLE, busy=0, no done; start with count 0 -> ignored.
- Reset asserted asynchronously mid-prescale (between clock edges) during RUN with count=4 -> outputs immediately count 0, zero=1, done=0, busy=0; after release, start is ignored until a load.
- With SC_REGCOUNTDOWN_AUTORELOAD_EN, load 2, start -> count sequence 2,1,2,1,... stepping every 4 cycles; done pulses every 8 cycles; busy stays 1; clear stops it.
